// File: rtl/branch_pc_sequencer.sv
// Program-counter owner and branch resolver: steps or redirects the PC, and
// holds fetch while a conditional branch waits on the ALU compare handshake.
module branch_pc_sequencer #(
  parameter int unsigned          PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
  parameter int unsigned          STEP     = 4,
  parameter int unsigned          TIMEOUT  = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                instr_valid_i,
  input  logic                branch_i,
  input  logic [2:0]          branch_ctrl_i,
  input  logic                tipo_j_i,
  input  logic [PC_WIDTH-1:0] target_i,
  input  logic                cmp_ack_i,
  input  logic                zero_flag_i,
  input  logic                bit_m_i,
  output logic                cmp_req_o,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                stall_o,
  output logic                flush_o,
  output logic                taken_o,
  output logic                illegal_o,
  output logic                timeout_o
);

  localparam int unsigned         CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [PC_WIDTH-1:0] STEP_V   = PC_WIDTH'(STEP);

  typedef enum logic {IDLE, WAIT_CMP} state_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_kind_e;

  state_e              state_q, state_d;
  br_kind_e            kind_q, kind_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                flush_q, flush_d;
  logic                taken_q, taken_d;
  logic                illegal_q, illegal_d;
  logic                timeout_q, timeout_d;

  logic [PC_WIDTH-1:0] pc_step;
  logic                cond_met;

  // Fall-through wraps naturally at the PC width.
  assign pc_step = pc_q + STEP_V;

  always_comb begin
    cond_met = 1'b0;
    case (kind_q)
      BR_EQ:          cond_met = zero_flag_i;
      BR_NE:          cond_met = ~zero_flag_i;
      BR_LT, BR_LTU:  cond_met = bit_m_i;
      BR_GE, BR_GEU:  cond_met = ~bit_m_i;
      default:        cond_met = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    kind_d    = kind_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    flush_d   = 1'b0;
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (instr_valid_i) begin
          if (branch_i) begin
            if (branch_ctrl_i[2:1] == 2'b01) begin
              pc_d      = pc_step;
              illegal_d = 1'b1;
            end else begin
              state_d = WAIT_CMP;
              kind_d  = br_kind_e'(branch_ctrl_i);
              tgt_d   = target_i;
              cnt_d   = '0;
            end
          end else if (tipo_j_i) begin
            if (target_i[1:0] == 2'b00) begin
              pc_d    = target_i;
              taken_d = 1'b1;
              flush_d = 1'b1;
            end else begin
              pc_d      = pc_step;
              illegal_d = 1'b1;
            end
          end else begin
            pc_d = pc_step;
          end
        end
      end

      WAIT_CMP: begin
        cnt_d = cnt_q + CNT_W'(1);
        // An ack on the last allowed cycle beats the timeout.
        if (cmp_ack_i) begin
          state_d = IDLE;
          if (cond_met && tgt_q[1:0] == 2'b00) begin
            pc_d    = tgt_q;
            taken_d = 1'b1;
            flush_d = 1'b1;
          end else if (cond_met) begin
            pc_d      = pc_step;
            illegal_d = 1'b1;
          end else begin
            pc_d = pc_step;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          pc_d      = pc_step;
          timeout_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      kind_q    <= BR_EQ;
      pc_q      <= RESET_PC;
      tgt_q     <= '0;
      cnt_q     <= '0;
      flush_q   <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      flush_q   <= flush_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign cmp_req_o = (state_q == WAIT_CMP);
  assign stall_o   = (state_q == WAIT_CMP);
  assign pc_o      = pc_q;
  assign flush_o   = flush_q;
  assign taken_o   = taken_q;
  assign illegal_o = illegal_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Self-checking bench: a transaction-level model predicts the PC and pulses
// every cycle, and directed vectors pin hand-computed values.
module tb_branch_pc_sequencer;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, branch, tipo_j, cmp_ack, zero_flag, bit_m;
  logic [2:0]  branch_ctrl;
  logic [31:0] target;
  logic        cmp_req, stall, flush, taken, illegal, timeout;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_pc_sequencer #(
    .PC_WIDTH (32),
    .RESET_PC (32'h0000_0000),
    .STEP     (4),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .instr_valid_i (instr_valid),
    .branch_i      (branch),
    .branch_ctrl_i (branch_ctrl),
    .tipo_j_i      (tipo_j),
    .target_i      (target),
    .cmp_ack_i     (cmp_ack),
    .zero_flag_i   (zero_flag),
    .bit_m_i       (bit_m),
    .cmp_req_o     (cmp_req),
    .pc_o          (pc),
    .stall_o       (stall),
    .flush_o       (flush),
    .taken_o       (taken),
    .illegal_o     (illegal),
    .timeout_o     (timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pending branch is a record with an age in waited cycles.
  typedef struct {
    bit          busy;
    int          age;
    logic [2:0]  kind;
    logic [31:0] tgt;
    logic [31:0] pc;
    bit          taken, flush, illegal, timeout;
  } model_t;

  model_t m;

  function automatic bit branch_holds(input logic [2:0] kind, input logic z, input logic lt);
    case (kind)
      3'b000:         return z;
      3'b001:         return !z;
      3'b100, 3'b110: return lt;
      default:        return !lt;
    endcase
  endfunction

  function automatic model_t go_to(input model_t s, input logic [31:0] t);
    model_t r = s;
    if (t % 4 == 0) begin
      r.pc = t; r.taken = 1; r.flush = 1;
    end else begin
      r.pc = s.pc + 32'd4; r.illegal = 1;
    end
    return r;
  endfunction

  function automatic model_t model_next(input model_t s);
    model_t r = s;
    r.taken = 0; r.flush = 0; r.illegal = 0; r.timeout = 0;
    if (s.busy) begin
      r.age = s.age + 1;
      if (cmp_ack) begin
        r.busy = 0;
        if (branch_holds(s.kind, zero_flag, bit_m)) r = go_to(r, s.tgt);
        else r.pc = s.pc + 32'd4;
      end else if (r.age == TIMEOUT) begin
        r.busy = 0; r.pc = s.pc + 32'd4; r.timeout = 1;
      end
    end else if (instr_valid) begin
      if (branch) begin
        if (branch_ctrl == 3'b010 || branch_ctrl == 3'b011) begin
          r.pc = s.pc + 32'd4; r.illegal = 1;
        end else begin
          r.busy = 1; r.age = 0; r.kind = branch_ctrl; r.tgt = target;
        end
      end else if (tipo_j) begin
        r = go_to(r, target);
      end else begin
        r.pc = s.pc + 32'd4;
      end
    end
    return r;
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r.busy = 0; r.age = 0; r.kind = 3'b000; r.tgt = '0; r.pc = '0;
    r.taken = 0; r.flush = 0; r.illegal = 0; r.timeout = 0;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_next(m);
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("model pc",      pc,      m.pc);
      check("model stall",   32'(stall),   32'(m.busy));
      check("model cmp_req", 32'(cmp_req), 32'(m.busy));
      check("model taken",   32'(taken),   32'(m.taken));
      check("model flush",   32'(flush),   32'(m.flush));
      check("model illegal", 32'(illegal), 32'(m.illegal));
      check("model timeout", 32'(timeout), 32'(m.timeout));
    end
  end

  task automatic apply(input logic v, input logic b, input logic [2:0] c, input logic j,
                       input logic [31:0] t, input logic a, input logic z, input logic lt);
    @(negedge clk);
    instr_valid = v; branch = b; branch_ctrl = c; tipo_j = j;
    target = t; cmp_ack = a; zero_flag = z; bit_m = lt;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();                                     apply(0, 0, 3'b000, 0, 32'h0, 0, 0, 0); endtask
  task automatic plain();                                   apply(1, 0, 3'b000, 0, 32'h0, 0, 0, 0); endtask
  task automatic br(input logic [2:0] c, input logic [31:0] t); apply(1, 1, c, 0, t, 0, 0, 0);         endtask
  task automatic jmp(input logic [31:0] t);                 apply(1, 0, 3'b000, 1, t, 0, 0, 0);     endtask
  task automatic ack(input logic z, input logic lt);        apply(0, 0, 3'b000, 0, 32'h0, 1, z, lt); endtask
  // Decode traffic while waiting: must be ignored.
  task automatic noise();                                   apply(1, 0, 3'b010, 1, 32'h500, 0, 1, 1); endtask

  task automatic clear_inputs();
    instr_valid = 0; branch = 0; branch_ctrl = 3'b000; tipo_j = 0;
    target = '0; cmp_ack = 0; zero_flag = 0; bit_m = 0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset pc", pc, 32'h0);
    check("reset stall", 32'(stall), 32'h0);
    check("reset cmp_req", 32'(cmp_req), 32'h0);
    check("reset pulses", {28'h0, taken, flush, illegal, timeout}, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    nop();   check("idle hold", pc, 32'h0);
    plain(); check("step 1", pc, 32'h4);
    plain(); check("step 2", pc, 32'h8);
    plain(); check("step 3", pc, 32'hC);

    // Reset in the middle of a compare drops the request at once.
    br(3'b000, 32'h40);
    check("enter wait cmp_req", 32'(cmp_req), 32'h1);
    #2 clear_inputs();
    rst_n = 1'b0;
    #1;
    check("async reset pc", pc, 32'h0);
    check("async reset cmp_req", 32'(cmp_req), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    repeat (4) plain();
    check("pc before beq", pc, 32'h10);
    br(3'b000, 32'h40); check("beq stall c1", 32'(stall), 32'h1);
    noise();            check("beq stall c2", 32'(stall), 32'h1);
                        check("beq pc held", pc, 32'h10);
    ack(1, 0);          check("beq taken pc", pc, 32'h40);
                        check("beq taken/flush", {30'h0, taken, flush}, 32'h3);
                        check("beq stall off", 32'(stall), 32'h0);
    nop();              check("beq pulse one cycle", {30'h0, taken, flush}, 32'h0);

    jmp(32'h20);        check("jump to 0x20", pc, 32'h20);
    br(3'b111, 32'h80); ack(0, 1); check("bgeu not taken", pc, 32'h24);
                                   check("bgeu no taken", 32'(taken), 32'h0);
    br(3'b001, 32'h8);  ack(0, 0); check("bne taken", pc, 32'h8);
    br(3'b100, 32'h30); ack(0, 1); check("blt taken", pc, 32'h30);
    br(3'b110, 32'h80); ack(1, 0); check("bltu not taken", pc, 32'h34);
    br(3'b000, 32'h80); ack(0, 0); check("beq not taken", pc, 32'h38);
    br(3'b101, 32'h60); ack(0, 0); check("bge taken", pc, 32'h60);

    jmp(32'h100);       check("jump pc", pc, 32'h100);
                        check("jump taken/flush", {30'h0, taken, flush}, 32'h3);
    apply(1, 1, 3'b000, 1, 32'h200, 0, 0, 0);
                        check("branch priority stall", 32'(stall), 32'h1);
                        check("branch priority pc", pc, 32'h100);
    ack(1, 0);          check("priority resolve", pc, 32'h200);

    br(3'b010, 32'h80); check("illegal 010 pc", pc, 32'h204);
                        check("illegal 010 pulse", 32'(illegal), 32'h1);
                        check("illegal no stall", 32'(stall), 32'h0);
    br(3'b011, 32'h80); check("illegal 011 pc", pc, 32'h208);
    jmp(32'h102);       check("misaligned jump pc", pc, 32'h20C);
                        check("misaligned jump flags", {29'h0, illegal, taken, flush}, 32'h4);
    br(3'b000, 32'h301); ack(1, 0);
                        check("misaligned taken pc", pc, 32'h210);
                        check("misaligned taken flags", {29'h0, illegal, taken, flush}, 32'h4);
    br(3'b001, 32'h301); ack(1, 0);
                        check("misaligned not taken", pc, 32'h214);
                        check("misaligned not taken flag", 32'(illegal), 32'h0);

    br(3'b000, 32'h80);
    for (int i = 1; i <= 16; i++) begin
      noise();
      if (i < 16) check("timeout wait stall", 32'(stall), 32'h1);
    end
    check("timeout pulse", 32'(timeout), 32'h1);
    check("timeout pc", pc, 32'h218);
    check("timeout stall off", 32'(stall), 32'h0);
    nop();
    check("timeout pulse one cycle", 32'(timeout), 32'h0);

    br(3'b000, 32'h400);
    for (int i = 1; i <= 15; i++) noise();
    ack(1, 0);
    check("late ack pc", pc, 32'h400);
    check("late ack no timeout", 32'(timeout), 32'h0);
    check("late ack taken", 32'(taken), 32'h1);

    apply(0, 0, 3'b000, 0, 32'h0, 1, 1, 0);
    check("stray ack pc", pc, 32'h400);
    check("stray ack stall", 32'(stall), 32'h0);

    jmp(32'hFFFF_FFFC); check("jump top", pc, 32'hFFFF_FFFC);
    plain();            check("wrap", pc, 32'h0);

    nop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
